// File: rtl/bcd_conv_sched_if.sv
// Request/grant/result bundle between the two display clients and the shared BCD engine.
// The master side is the requester pair; the slave side is the conversion engine.
interface bcd_conv_sched_if #(
    parameter int WIDTH = 12
);
    logic             req0;
    logic [WIDTH-1:0] bin0;
    logic             req1;
    logic [WIDTH-1:0] bin1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done0;
    logic             done1;
    logic [3:0]       thousands;
    logic [3:0]       hundreds;
    logic [3:0]       tens;
    logic [3:0]       ones;

    modport master (
        output req0, bin0, req1, bin1,
        input  gnt0, gnt1, busy, done0, done1, thousands, hundreds, tens, ones
    );

    modport slave (
        input  req0, bin0, req1, bin1,
        output gnt0, gnt1, busy, done0, done1, thousands, hundreds, tens, ones
    );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared serial double-dabble binary-to-BCD engine with a two-port round-robin scheduler.
// state   | meaning
// S_IDLE  | arbitrate requests, latch winner's value
// S_SHIFT | one add-3/shift step per cycle, MSB first
// S_DONE  | publish digits and pulse the owner's done
module bcd_conv_sched #(
    parameter int WIDTH = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bcd_conv_sched_if.slave      bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [15:0]      r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_owner;
    logic             r_last;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_busy;
    logic             r_done0;
    logic             r_done1;
    logic [15:0]      r_dig;
    logic             w_take0;
    logic             w_take1;
    logic [15:0]      w_adj;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Tie goes to whichever requester was not served last.
    always_comb begin
        w_state_nxt = r_state;
        w_take0     = 1'b0;
        w_take1     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 && (!bus.req1 || r_last)) w_take0 = 1'b1;
                else if (bus.req1)                     w_take1 = 1'b1;
                if (w_take0 || w_take1) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < 4; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr    <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_busy  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_dig   <= '0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= w_take0 || w_take1;
                    if (w_take0 || w_take1) begin
                        r_sr    <= w_take1 ? bus.bin1 : bus.bin0;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_owner <= w_take1;
                        r_last  <= w_take1;
                        r_gnt0  <= w_take0;
                        r_gnt1  <= w_take1;
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_sr} <= {w_adj, r_sr} << 1;
                    r_cnt         <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_dig   <= r_bcd;
                    r_done0 <= !r_owner;
                    r_done1 <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0  = r_gnt0;
    assign bus.gnt1  = r_gnt1;
    assign bus.busy  = r_busy;
    assign bus.done0 = r_done0;
    assign bus.done1 = r_done1;
    assign {bus.thousands, bus.hundreds, bus.tens, bus.ones} = r_dig;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for the shared BCD engine: per-requester value queues feed the DUT, grants push the
// expected result (decimal arithmetic) into a scoreboard, and a negedge monitor checks each done.
module tb_bcd_conv_sched;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_conv_sched_if #(.WIDTH(W)) bus();

    bcd_conv_sched #(.WIDTH(W)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int val;
        int gcyc;
    } exp_t;

    exp_t sb[$];
    int   q0[$];
    int   q1[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_m = 1;
    int   prev_g = -100;
    bit   pend_b2b = 1'b0;
    int   scr0 = 0;
    int   scr1 = 0;
    int   junk0 = 999;
    int   junk1 = 999;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp_v, exp_v, cyc);
        end
    endtask

    function automatic int bcd_of(input int v);
        return (v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // Driver reaction to what the DUT shows this cycle (runs 2 time units after the edge).
    task automatic handle();
        int   id;
        int   pid;
        exp_t e;
        if (bus.gnt0 || bus.gnt1) begin
            id  = bus.gnt1 ? 1 : 0;
            pid = (bus.req0 && bus.req1) ? 1 - last_m : (bus.req1 ? 1 : 0);
            chk("grant_id", id, pid);
            last_m = id;
            if (pend_b2b) chk("grant_gap", cyc - prev_g, 14);
            pend_b2b = 1'b0;
            prev_g   = cyc;
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                n_chk++;
                n_err++;
                $display("FAIL grant_unrequested: got grant %0d expected none at cycle %0d", id, cyc);
            end else begin
                e.id   = id;
                e.val  = (id == 0) ? q0.pop_front() : q1.pop_front();
                e.gcyc = cyc;
                sb.push_back(e);
                if (id == 0) scr0 = 2;
                else         scr1 = 2;
            end
        end
        if (scr0 > 0) begin
            scr0--;
            if (scr0 == 0) bus.bin0 = W'(junk0);
        end
        if (scr1 > 0) begin
            scr1--;
            if (scr1 == 0) bus.bin1 = W'(junk1);
        end
        if (bus.done0) begin
            if (q0.size() > 0) bus.bin0 = W'(q0[0]);
            else               bus.req0 = 1'b0;
        end
        if (bus.done1) begin
            if (q1.size() > 0) bus.bin1 = W'(q1[0]);
            else               bus.req1 = 1'b0;
        end
        if (bus.done0 || bus.done1) pend_b2b = bus.req0 || bus.req1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        handle();
    endtask

    task automatic load(input int id, input int v);
        if (id == 0) begin
            q0.push_back(v);
            if (!bus.req0) begin
                bus.bin0 = W'(v);
                bus.req0 = 1'b1;
            end
        end else begin
            q1.push_back(v);
            if (!bus.req1) begin
                bus.bin1 = W'(v);
                bus.req1 = 1'b1;
            end
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || bus.busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_err++;
            $display("FAIL run_timeout: got %0d cycles expected under %0d", n, budget);
        end
        step();
        step();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        rst      = 1'b0;
        sb.delete();
        q0.delete();
        q1.delete();
        last_m   = 1;
        pend_b2b = 1'b0;
        scr0     = 0;
        scr1     = 0;
    endtask

    // Monitor: pops the scoreboard on every done and polices the pulse/hold rules.
    logic [15:0] m_dig;
    logic [15:0] prev_dig = '0;
    bit          chk_busy = 1'b0;
    exp_t        m_e;

    always @(negedge clk) begin
        m_dig = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
        if (rst) begin
            prev_dig = '0;
            chk_busy = 1'b0;
        end else begin
            chk("gnt_exclusive", int'(bus.gnt0 & bus.gnt1), 0);
            chk("done_exclusive", int'(bus.done0 & bus.done1), 0);
            if (chk_busy) begin
                if (!bus.gnt0 && !bus.gnt1) chk("busy_after_done", int'(bus.busy), 0);
                chk_busy = 1'b0;
            end
            if (bus.done0 || bus.done1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done: got done%0d expected none at cycle %0d",
                             bus.done1 ? 1 : 0, cyc);
                end else begin
                    m_e = sb.pop_front();
                    chk("done_id", bus.done1 ? 1 : 0, m_e.id);
                    chk("digits", int'(m_dig), bcd_of(m_e.val));
                    chk("latency", cyc - m_e.gcyc, 13);
                end
                chk_busy = 1'b1;
            end else begin
                chk("digits_held", int'(m_dig), int'(prev_dig));
            end
            prev_dig = m_dig;
        end
    end

    initial begin
        int n;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.bin0 = '0;
        bus.bin1 = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_gnt", int'({bus.gnt1, bus.gnt0}), 0);
        chk("rst_done", int'({bus.done1, bus.done0}), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_digits", int'({bus.thousands, bus.hundreds, bus.tens, bus.ones}), 0);

        load(0, 4095);
        run(100);

        load(1, 0);
        load(1, 255);
        run(200);

        do_reset();
        load(0, 1234);
        load(1, 987);
        run(200);

        load(0, 17);
        load(1, 3002);
        load(0, 999);
        load(1, 4090);
        run(300);

        junk0 = 999;
        load(0, 42);
        run(100);

        // Abort a conversion of 4000 partway through the shift phase.
        load(0, 4000);
        n = 0;
        while (!bus.gnt0 && n < 20) begin
            step();
            n++;
        end
        chk("abort_grant_seen", int'(bus.gnt0), 1);
        repeat (6) step();
        do_reset();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_digits", int'({bus.thousands, bus.hundreds, bus.tens, bus.ones}), 0);
        repeat (20) step();
        chk("abort_idle_busy", int'(bus.busy), 0);
        load(0, 3579);
        load(1, 2468);
        run(200);

        for (int r = 0; r < 8; r++) begin
            junk0 = int'($urandom_range(0, 4095));
            junk1 = int'($urandom_range(0, 4095));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) load(0, int'($urandom_range(0, 4095)));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) load(1, int'($urandom_range(0, 4095)));
            repeat (int'($urandom_range(0, 3))) step();
            run(500);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Shared, sequential binary-to-BCD conversion engine with a two-port round-robin scheduler. Intended clients are the credit display path and the item-count display path.
- Each grant latches one requester's binary value and runs a serial double-dabble over WIDTH clock cycles, one bit per cycle.
- Returns four BCD digits plus a per-requester done pulse.
- Replaces duplicated combinational converters with one time-multiplexed datapath.

Parameters:
- WIDTH, 12, binary input width. Legal range 4..13, so the result always fits in 4 BCD digits. Number of shift cycles = WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 conversion request (level)
- bin0  in  WIDTH  requester 0 binary value; sampled only on the grant edge
- req1  in  1  requester 1 conversion request (level)
- bin1  in  WIDTH  requester 1 binary value; sampled only on the grant edge
- gnt0  out  1  one-cycle pulse: bin0 latched
- gnt1  out  1  one-cycle pulse: bin1 latched
- busy  out  1  high from the grant edge until the cycle after done
- done0  out  1  one-cycle pulse: result for requester 0 valid
- done1  out  1  one-cycle pulse: result for requester 1 valid
- thousands  out  4  BCD digit, held until the next done
- hundreds  out  4  BCD digit, held until the next done
- tens  out  4  BCD digit, held until the next done
- ones  out  4  BCD digit, held until the next done

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state<=IDLE.
  - All outputs 0.
  - Shift count 0.
  - Round-robin pointer last<=1, so req0 wins the first tie.
  - Reset mid-conversion aborts the conversion. No done is issued. Digits are cleared to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - No req: stay in IDLE, busy=0.
  - Only one req high: grant it.
  - Both high: grant the requester not equal to last.
  - On the grant edge:
    - Latch bin into the shift register.
    - Clear the BCD working register.
    - cnt<=0; owner<=granted id; last<=granted id.
    - Pulse gnt for the following cycle; busy<=1.
    - state<=SHIFT.
- SHIFT, one edge per bit, MSB first:
  - Each working digit >=5 gets +3 (4-bit wrap impossible).
  - Then shift {thousands,hundreds,tens,ones,bin} left by 1.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: state<=DONE.
- DONE, one edge:
  - Copy working digits to the output registers.
  - Assert done[owner] for exactly one cycle.
  - state<=IDLE.
  - busy<=0 on the edge after done.
- Latency (E0 = grant edge): shifts occur on E1..E(WIDTH); outputs and done register on E(WIDTH+1); done is high for the cycle following it. For WIDTH=12, done is visible 13 cycles after the grant edge.
- Throughput: IDLE re-arbitrates on the edge after done is visible. Back-to-back grants are therefore WIDTH+2 cycles apart (14 for WIDTH=12).
- Requests:
  - A req that arrives while busy is ignored until IDLE, then arbitrated.
  - Requesters must drop req in the cycle that their done is high, or they are re-granted.
  - A req dropped after its grant does not abort the conversion; done still pulses.
  - Changes to bin after the grant edge have no effect.
- gnt0/gnt1 are never both high. done0/done1 are never both high.
- Digit outputs are unchanged except on the DONE edge or on reset.

Test Plan:
- Reset, then req0=1 with bin0=12'd4095 and held -> gnt0 pulse one cycle after the sampling edge; done0 13 cycles after the grant edge with digits 4,0,9,5; busy low the cycle after done0.
- bin1=0 then bin1=255, each a separate req1 transaction -> first done1 gives 0,0,0,0; second gives 0,2,5,5; no done0 pulses.
- req0 and req1 asserted in the same cycle from reset (bin0=1234, bin1=987), each held until its done -> grant order 0 then 1; digits 1,2,3,4 then 0,9,8,7; grants 14 cycles apart.
- Both reqs held continuously for 4 transactions -> strictly alternating gnt0,gnt1,gnt0,gnt1.
- bin0 changed to 999 two cycles after gnt0 -> result still reflects the latched value.
- rst=1 for one cycle at shift 6 of a conversion of 4000 -> no done; digits 0; busy 0; the next req0 converts correctly and wins the first tie again.
